// File: rtl/subtractor_4bit_if.sv
// subtractor_4bit_if: operand/result bundle for the registered subtractor
interface subtractor_4bit_if #(parameter int WIDTH = 4) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             C_in;
  logic [WIDTH-1:0] d;
  logic             B_out;
  modport master (output a, b, C_in, input d, B_out);
  modport slave (input a, b, C_in, output d, B_out);
endinterface

// File: rtl/subtractor_4bit.sv
// subtractor_4bit: ripple-borrow a - b - C_in with registered difference and borrow-out
module subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  subtractor_4bit_if.slave   io
);
  logic [WIDTH-1:0] d_d, d_q;
  logic             b_d, b_q;
  always_comb begin
    d_d = '0;
    b_d = io.C_in;
    for (int k = 0; k < WIDTH; k++) begin
      d_d[k] = io.a[k] ^ io.b[k] ^ b_d;
      b_d = (~io.a[k] & io.b[k]) | (~(io.a[k] ^ io.b[k]) & b_d);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      b_q <= 1'b0;
    end else begin
      d_q <= d_d;
      b_q <= b_d;
    end
  end
  assign io.d = d_q;
  assign io.B_out = b_q;
endmodule

// File: tb/tb_subtractor_4bit.sv
// tb_subtractor_4bit: directed and random checks against an arithmetic reference
module tb_subtractor_4bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [4:0] last = '0;
  logic armed = 1'b0;
  always #5 clk = ~clk;
  subtractor_4bit_if #(.WIDTH(4)) sub_if ();
  subtractor_4bit #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .io(sub_if));
  function automatic logic [4:0] ref_sub(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {4'b0, c};
  endfunction
  task automatic run(input string tag, input logic [3:0] av, input logic [3:0] bv,
                     input logic cv, input logic rv, input logic [4:0] exp);
    logic [4:0] got;
    @(negedge clk);
    sub_if.a = av;
    sub_if.b = bv;
    sub_if.C_in = cv;
    rst = rv;
    #1;
    if (armed) begin
      got = {sub_if.B_out, sub_if.d};
      checks++;
      assert (got === last) else begin
        errors++;
        $error("FAIL %s hold: got B=%0d d=%0d expected B=%0d d=%0d", tag, got[4], got[3:0], last[4], last[3:0]);
      end
    end
    @(posedge clk);
    #1;
    got = {sub_if.B_out, sub_if.d};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got B=%0d d=%0d expected B=%0d d=%0d", tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
    last = exp;
    armed = 1'b1;
  endtask
  initial begin
    logic [3:0] ra, rb;
    logic rc;
    sub_if.a = '0;
    sub_if.b = '0;
    sub_if.C_in = 1'b0;
    run("reset0", 4'd7, 4'd4, 1'b0, 1'b1, 5'd0);
    run("reset1", 4'd15, 4'd1, 1'b1, 1'b1, 5'd0);
    run("first", 4'd7, 4'd4, 1'b0, 1'b0, {1'b0, 4'd3});
    run("c0_0_0", 4'd0, 4'd0, 1'b0, 1'b0, {1'b0, 4'd0});
    run("c0_14_12", 4'd14, 4'd12, 1'b0, 1'b0, {1'b0, 4'd2});
    run("c0_4_1", 4'd4, 4'd1, 1'b0, 1'b0, {1'b0, 4'd3});
    run("c0_5_4", 4'd5, 4'd4, 1'b0, 1'b0, {1'b0, 4'd1});
    run("c0_15_15", 4'd15, 4'd15, 1'b0, 1'b0, {1'b0, 4'd0});
    run("c0_1_9", 4'd1, 4'd9, 1'b0, 1'b0, {1'b1, 4'd8});
    run("c0_10_13", 4'd10, 4'd13, 1'b0, 1'b0, {1'b1, 4'd13});
    run("c1_14_7", 4'd14, 4'd7, 1'b1, 1'b0, {1'b0, 4'd6});
    run("c1_6_9", 4'd6, 4'd9, 1'b1, 1'b0, {1'b1, 4'd12});
    run("c1_3_12", 4'd3, 4'd12, 1'b1, 1'b0, {1'b1, 4'd6});
    run("c1_4_9", 4'd4, 4'd9, 1'b1, 1'b0, {1'b1, 4'd10});
    run("c1_9_4", 4'd9, 4'd4, 1'b1, 1'b0, {1'b0, 4'd4});
    run("c1_10_9", 4'd10, 4'd9, 1'b1, 1'b0, {1'b0, 4'd0});
    run("c1_15_5", 4'd15, 4'd5, 1'b1, 1'b0, {1'b0, 4'd9});
    run("c1_2_15", 4'd2, 4'd15, 1'b1, 1'b0, {1'b1, 4'd2});
    run("max_under", 4'd0, 4'd15, 1'b1, 1'b0, {1'b1, 4'd0});
    run("max_pos", 4'd15, 4'd0, 1'b0, 1'b0, {1'b0, 4'd15});
    run("eq_borrow", 4'd5, 4'd5, 1'b1, 1'b0, {1'b1, 4'd15});
    for (int n = 0; n < 16; n++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      run("b2b", ra, rb, rc, 1'b0, ref_sub(ra, rb, rc));
    end
    run("mid_rst", 4'd9, 4'd4, 1'b0, 1'b1, 5'd0);
    run("post_rst", 4'd9, 4'd4, 1'b0, 1'b0, {1'b0, 4'd5});
    for (int k = 0; k < 512; k++) begin
      ra = 4'(k >> 5);
      rb = 4'(k >> 1);
      rc = 1'(k);
      run("sweep", ra, rb, rc, 1'b0, ref_sub(ra, rb, rc));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
